mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the IF stage fetch path and the MEM stage load/store path of the 5-stage pipeline. Requests are taken through registered grants. Each access is one memory transaction closed by a one-cycle response pulse. Combinational stall outputs freeze the requesting stage until its response arrives.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (guard build only); range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  branch redirect (doBranch); cancels an outstanding fetch response
- ireq_valid  in  1  fetch request; held with ireq_addr stable until iresp_valid
- ireq_addr  in  ADDR_W  fetch address
- iresp_valid  out  1  one-cycle fetch response pulse
- irdata  out  DATA_W  fetched instruction, valid with iresp_valid
- dreq_valid  in  1  data request; held with dreq_we/dreq_addr/dreq_wdata stable until dresp_valid
- dreq_we  in  1  1 = store, 0 = load
- dreq_addr  in  ADDR_W  data address
- dreq_wdata  in  DATA_W  store data
- dresp_valid  out  1  one-cycle data response pulse
- drdata  out  DATA_W  load data, valid with dresp_valid
- stall_if  out  1  ireq_valid & ~iresp_valid
- stall_mem  out  1  dreq_valid & ~dresp_valid
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; may assert in the first mem_req cycle; mem_rdata valid with it
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- IDLE:
  - dreq_valid → GRANT_D; else ireq_valid → GRANT_I; else stay.
  - Data has priority because the MEM stage holds the older instruction.
- GRANT_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata are taken from the granted requester.
  - mem_we=0 for instruction grants.
  - On mem_ack: latch mem_rdata into irdata (GRANT_I) or drdata (load in GRANT_D), then → RESP_x.
  - Stores leave drdata unchanged.
- RESP_x:
  - Pulse the matching resp_valid for one cycle, then → IDLE.
  - No arbitration in this state; the requester drops or changes its request by the end of the RESP cycle.
- Flush:
  - Flush in GRANT_I: the memory transaction still completes and irdata is still latched.
  - Flush in GRANT_I sets a cancel flag that suppresses the following iresp_valid. The state still passes through RESP_I.
  - Flush in RESP_I masks iresp_valid in that same cycle.
  - Flush has no effect on data accesses.
- stall_if/stall_mem are combinational from the request and response signals.
- While not in GRANT_x, mem_req=0 and mem_we=0; mem_addr/mem_wdata are don't-care, driven 0.

## Timing
- Reset (rst=0, async):
  - state=IDLE; cancel flag=0; starvation counter=0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, iresp_valid, dresp_valid, irdata, drdata.
  - stall_* follow their inputs.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and the memory side sees mem_req drop asynchronously.
- Latency:
  - Request seen in IDLE at cycle 0.
  - mem_req high at cycle 1.
  - With mem_ack at cycle 1+k, resp_valid is high at cycle 2+k.
  - Minimum 3 cycles per access. Back-to-back throughput is one access per 3 cycles at k=0.
- Simultaneous ireq and dreq in IDLE: data wins, and the fetch is granted in the IDLE after RESP_D unless a new dreq is present.
- Requests that change while granted violate the protocol; the behaviour is undefined and is not checked.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on every D grant made while ireq_valid=1.
  - The counter clears on an I grant or whenever ireq_valid=0.
  - In IDLE with counter==STARVE_MAX and ireq_valid=1, the fetch is granted even if dreq_valid=1.
- Not defined: strict data priority; the counter is not built; fetch may starve indefinitely.

## Structure
- Shared package cpu_pkg holds:
  - the arb_state_t enum (IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D)
  - MEM_ADDR_W/MEM_DATA_W constants shared with MEM and IFetch.
- Optional sub-module mem_arb_starve_ctr (counter plus compare) is instantiated only under MEM_ARB_STARVE_GUARD_EN; the FSM stays in the top module.

## Test plan
- Single load: dreq addr 0x10, mem_ack in the first mem_req cycle with rdata 0xDEADBEEF → dresp_valid at cycle 2, drdata=0xDEADBEEF, stall_mem high during cycles 0–1.
- Collision: ireq 0x0 and dreq load 0x20 at the same cycle, 2-cycle mem latency → D served first (dresp at cycle 3), then I (iresp at cycle 7).
- Store then fetch: dreq_we=1, addr 0x40, wdata 0x1234 → mem_we=1 with matching addr/data, drdata unchanged, next fetch mem_we=0.
- Flush: flush during GRANT_I with mem_ack delayed 3 cycles → memory sees one request, iresp_valid never pulses, and the next fetch completes normally.
- Starvation (guard on, STARVE_MAX=4): dreq held continuously with ireq pending → exactly 4 D grants, then an I grant, then D resumes. Guard off: no I grant while dreq is held.
- Reset mid-access: rst low while in GRANT_D → all outputs 0 immediately, no dresp after release, and a fresh request is served from IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and widths shared by the IF, MEM and memory-arbiter blocks of the pipeline.
package cpu_pkg;
   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      RESP_I,
      RESP_D
   } arb_state_t;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants made while a fetch waits; flags when the fetch must be let through.
module mem_arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ireq_valid,
   input  logic i_grant,
   input  logic d_grant,
   output logic starve
);
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!ireq_valid || i_grant) begin
         cnt_d = '0;
      end else if (d_grant) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve = (cnt_q == 4'(STARVE_MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data wins unless MEM_ARB_STARVE_GUARD_EN
// is defined, which forces a fetch grant after STARVE_MAX back-to-back data grants.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ireq_valid,
   input  logic [ADDR_W-1:0] ireq_addr,
   output logic              iresp_valid,
   output logic [DATA_W-1:0] irdata,
   input  logic              dreq_valid,
   input  logic              dreq_we,
   input  logic [ADDR_W-1:0] dreq_addr,
   input  logic [DATA_W-1:0] dreq_wdata,
   output logic              dresp_valid,
   output logic [DATA_W-1:0] drdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);
   arb_state_t        state_q, state_d;
   logic              cancel_q, cancel_d;
   logic [DATA_W-1:0] irdata_q, irdata_d;
   logic [DATA_W-1:0] drdata_q, drdata_d;
   logic              starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic i_grant, d_grant;

   assign i_grant = (state_q == IDLE) && ireq_valid && (starve || !dreq_valid);
   assign d_grant = (state_q == IDLE) && dreq_valid && !(ireq_valid && starve);

   mem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk        (clk),
      .rst        (rst),
      .ireq_valid (ireq_valid),
      .i_grant    (i_grant),
      .d_grant    (d_grant),
      .starve     (starve)
   );
`else
   // Strict data priority: the fetch-forcing override never fires.
   assign starve = 1'b0 & (STARVE_MAX != 0);
`endif

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      unique case (state_q)
         IDLE: begin
            if (ireq_valid && (starve || !dreq_valid)) begin
               state_d = GRANT_I;
            end else if (dreq_valid) begin
               state_d = GRANT_D;
            end
         end
         GRANT_I: begin
            // A redirect cannot abort the bus cycle, so remember to swallow its response.
            if (flush) begin
               cancel_d = 1'b1;
            end
            if (mem_ack) begin
               irdata_d = mem_rdata;
               state_d  = RESP_I;
            end
         end
         GRANT_D: begin
            if (mem_ack) begin
               if (!dreq_we) begin
                  drdata_d = mem_rdata;
               end
               state_d = RESP_D;
            end
         end
         RESP_I: begin
            cancel_d = 1'b0;
            state_d  = IDLE;
         end
         RESP_D: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cancel_q <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   // Memory-side signals decode straight from the state register so reset drops mem_req at once.
   assign mem_req   = (state_q == GRANT_I) || (state_q == GRANT_D);
   assign mem_we    = (state_q == GRANT_D) && dreq_we;
   assign mem_addr  = (state_q == GRANT_I) ? ireq_addr :
                      (state_q == GRANT_D) ? dreq_addr : '0;
   assign mem_wdata = (state_q == GRANT_D) ? dreq_wdata : '0;

   assign iresp_valid = (state_q == RESP_I) && !cancel_q && !flush;
   assign dresp_valid = (state_q == RESP_D);
   assign irdata      = irdata_q;
   assign drdata      = drdata_q;

   assign stall_if  = ireq_valid && !iresp_valid;
   assign stall_mem = dreq_valid && !dresp_valid;
endmodule
